// File: rtl/dadda_mac_pkg.sv
// Shared types and constants for the Dadda multiply-accumulate slice.
// Holds defaults, the debug FSM encoding and the carry-save helper.
package dadda_mac_pkg;

    localparam int ACC_W_DEF = 20;
    localparam int CNT_W_DEF = 8;
    localparam logic [15:0] MAX_PROD = 16'd65025;

    typedef enum logic {
        EMPTY,
        ACCUM
    } state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       last;
    } s1_t;

    typedef struct packed {
        logic [15:0] s;
        logic [15:0] c;
    } csa_t;

    // 3:2 compressor on whole rows; carries beyond bit 15 are dropped
    // because the final product always fits in 16 bits.
    function automatic csa_t csa(input logic [15:0] x,
                                 input logic [15:0] y,
                                 input logic [15:0] z);
        csa_t r;
        logic [15:0] maj;
        maj = (x & y) | (x & z) | (y & z);
        r.s = x ^ y ^ z;
        r.c = {maj[14:0], 1'b0};
        return r;
    endfunction

endpackage

// File: rtl/dadda_8x8_compressed.sv
// Unsigned 8x8 multiplier: partial products reduced 8-6-4-3-2
// through carry-save compressors, then one carry-propagate add.
module dadda_8x8_compressed
    import dadda_mac_pkg::*;
(
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] P
);

    logic [15:0] pp [8];
    csa_t l1a, l1b, l2a, l2b, l3, l4;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pp[i] = b[i] ? (16'(a) << i) : '0;
        end
    end

    assign l1a = csa(pp[0], pp[1], pp[2]);
    assign l1b = csa(pp[3], pp[4], pp[5]);
    assign l2a = csa(l1a.s, l1a.c, l1b.s);
    assign l2b = csa(l1b.c, pp[6], pp[7]);
    assign l3  = csa(l2a.s, l2a.c, l2b.s);
    assign l4  = csa(l3.s, l3.c, l2b.c);
    assign P   = l4.s + l4.c;

endmodule

// File: rtl/dadda_mac_acc.sv
// Streaming dot-product unit: operand register, Dadda multiplier,
// wide accumulator and a skid-free result register.
module dadda_mac_acc
    import dadda_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    logic             s1_valid;
    s1_t              s1_q;
    logic [15:0]      prod;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_q;
    logic             stall;
    logic             fire;
    logic             fire_last;
    logic [ACC_W:0]   sum_ext;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;
    state_t           state_q;
    state_t           state_d;
    logic             is_empty;

    dadda_8x8_compressed u_mul (
        .a (s1_q.a),
        .b (s1_q.b),
        .P (prod)
    );

    // Only a last pair can block: it needs the result register free.
    assign stall     = s1_valid && s1_q.last && out_valid && !out_ready;
    assign in_ready  = !stall;
    assign fire      = s1_valid && !stall;
    assign fire_last = fire && s1_q.last;

    assign sum_ext  = {1'b0, acc} + (ACC_W + 1)'(prod);
    assign ovf_next = ovf_q | sum_ext[ACC_W];
    assign cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= '{a: in_a, b: in_b, last: in_last};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (fire_last) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (fire) begin
            acc   <= sum_ext[ACC_W-1:0];
            cnt   <= cnt_next;
            ovf_q <= ovf_next;
        end
    end

    // A new result may replace the one being read in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (fire_last) begin
            out_valid <= 1'b1;
            out_acc   <= sum_ext[ACC_W-1:0];
            out_count <= cnt_next;
            out_ovf   <= ovf_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            fire_last:               state_d = EMPTY;
            fire && !s1_q.last:      state_d = ACCUM;
            default:                 state_d = state_q;
        endcase
    end

    always_comb begin
        is_empty = 1'b0;
        unique case (state_q)
            EMPTY:   is_empty = 1'b1;
            ACCUM:   is_empty = 1'b0;
            default: is_empty = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (is_empty) begin
                assert (acc == '0 && cnt == '0);
            end
            assert (prod <= MAX_PROD);
        end
    end

endmodule

// File: tb/tb_dadda_mac_acc.sv
// Scoreboard bench for dadda_mac_acc: directed groups push expected
// results, a negedge monitor pops them on each output transfer.
module tb_dadda_mac_acc;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_acc;
    logic [7:0]  out_count;
    logic        out_ovf;

    typedef struct {
        logic [19:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic rnd = 1'b0;

    dadda_mac_acc #(.ACC_W(20), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int acc, input int cnt, input int ovf);
        exp_t e;
        e.acc = acc[19:0];
        e.cnt = cnt[7:0];
        e.ovf = ovf[0];
        q.push_back(e);
    endtask

    // Present a pair and hold it until the edge that accepts it.
    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic l);
        int n;
        n = 0;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic        hold_prev = 1'b0;
    logic [28:0] prev;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (hold_prev) begin
                chk("hold_stable", {3'b0, out_acc, out_count, out_ovf},
                    {3'b0, prev});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got acc %0d expected none",
                             out_acc);
                end else begin
                    e = q.pop_front();
                    chk("out_acc", 32'(out_acc), 32'(e.acc));
                    chk("out_count", 32'(out_count), 32'(e.cnt));
                    chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
                end
            end
            hold_prev = out_valid && !out_ready;
            prev      = {out_acc, out_count, out_ovf};
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        int unsigned tot;
        int          n;
        int          w;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        l;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_acc", 32'(out_acc), 0);
        chk("rst_out_count", 32'(out_count), 0);
        chk("rst_out_ovf", 32'(out_ovf), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        push(65025, 1, 0);
        send(8'd255, 8'd255, 1'b1);
        chk("latency_t", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("latency_t1", 32'(out_valid), 1);

        push(178, 4, 0);
        send(8'd3, 8'd5, 1'b0);
        send(8'd10, 8'd10, 1'b0);
        send(8'd0, 8'd200, 1'b0);
        send(8'd7, 8'd9, 1'b1);
        push(2, 1, 0);
        send(8'd1, 8'd2, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        out_ready = 1'b0;
        push(6, 1, 0);
        send(8'd2, 8'd3, 1'b1);
        push(41, 2, 0);
        send(8'd4, 8'd4, 1'b0);
        send(8'd5, 8'd5, 1'b1);
        chk("stall_in_ready", 32'(in_ready), 0);
        push(1, 1, 0);
        fork
            send(8'd1, 8'd1, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("stall_hold_ready", 32'(in_ready), 0);
                chk("stall_hold_acc", 32'(out_acc), 6);
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                chk("nobubble_valid", 32'(out_valid), 1);
                chk("nobubble_acc", 32'(out_acc), 41);
            end
        join
        repeat (3) @(posedge clk);
        #1;

        push(56849, 17, 1);
        for (int i = 0; i < 16; i++) send(8'd255, 8'd255, 1'b0);
        send(8'd255, 8'd255, 1'b1);
        push(65025, 1, 0);
        send(8'd255, 8'd255, 1'b1);

        push(300, 255, 0);
        for (int i = 0; i < 299; i++) send(8'd1, 8'd1, 1'b0);
        send(8'd1, 8'd1, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) send(8'd9, 8'd9, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        push(4, 1, 0);
        send(8'd2, 8'd2, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        rnd = 1'b1;
        tot = 0;
        n   = 0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                out_ready = 1'($urandom_range(0, 1));
            end
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            l = ($urandom_range(0, 7) == 0) || (k == 1499);
            send(a, b, l);
            tot += int'(a) * int'(b);
            n++;
            if (l) begin
                push(int'(tot), (n > 255) ? 255 : n,
                     (tot > 32'hFFFFF) ? 1 : 0);
                tot = 0;
                n   = 0;
            end
        end
        rnd       = 1'b0;
        out_ready = 1'b1;

        w = 0;
        while (q.size() != 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain_left", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
